inst_fetch: RTL and testbench

//   Instruction fetch stage directly downstream of the PC register: latches PCOut/PC4, reads the

---
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: reads the word at the current PC from a variable-latency memory,
// hands it to decode over valid/ready, and pulses pc_wre once decode accepts it or on a redirect.
module inst_fetch #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    output logic        pc_wre,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        fetch_err,
    output logic [31:0] err_pc
);

    typedef enum logic [2:0] {
        ISSUE = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        DRAIN = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic             timeout_hit;
    logic             in_fault;

    // The counter holds the number of ack-less cycles already spent, so the
    // TIMEOUT-th such cycle is the one that sees cnt == TIMEOUT-1.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign in_fault    = (state == FAULT);

    // Decode handshake and PC write-enable have to act in the same cycle, so they stay combinational.
    assign out_valid = (state == HOLD) && !flush;
    assign pc_wre    = !in_fault && (flush || ((state == HOLD) && out_ready));

    assign imem_addr = addr_q;
    assign out_pc    = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ISSUE;
            cnt       <= '0;
            addr_q    <= '0;
            imem_req  <= 1'b0;
            out_instr <= '0;
            out_pc4   <= '0;
            fetch_err <= 1'b0;
            err_pc    <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    // A redirect in ISSUE only reloads the PC; the new value is picked up next cycle.
                    if (!flush) begin
                        addr_q  <= pc_in;
                        out_pc4 <= pc4_in;
                        if (pc_in[1:0] != 2'b00) begin
                            state     <= FAULT;
                            fetch_err <= 1'b1;
                            err_pc    <= pc_in;
                        end else begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                end

                REQ: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (flush) begin
                            state <= ISSUE;
                        end else begin
                            out_instr <= imem_rdata;
                            state     <= HOLD;
                        end
                    end else if (flush) begin
                        // The request is still in flight; its ack must be absorbed before refetching.
                        imem_req <= 1'b0;
                        cnt      <= '0;
                        state    <= DRAIN;
                    end else if (timeout_hit) begin
                        imem_req  <= 1'b0;
                        state     <= FAULT;
                        fetch_err <= 1'b1;
                        err_pc    <= addr_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (flush || out_ready) begin
                        state <= ISSUE;
                    end
                end

                DRAIN: begin
                    if (imem_ack) begin
                        state <= ISSUE;
                    end else if (timeout_hit) begin
                        state     <= FAULT;
                        fetch_err <= 1'b1;
                        err_pc    <= addr_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FAULT: begin
                    imem_req <= 1'b0;
                end

                default: begin
                    state     <= FAULT;
                    imem_req  <= 1'b0;
                    fetch_err <= 1'b1;
                    err_pc    <= addr_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: PC register and variable-latency memory models, with a
// scoreboard of expected (pc, instr) pairs popped whenever decode accepts an instruction.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, pc4_in;
    logic        pc_wre, flush;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pc4;
    logic        fetch_err;
    logic [31:0] err_pc;

    // Second instance with a short timeout and a memory that never answers
    logic        rst_t;
    logic        t_pc_wre, t_imem_req, t_out_valid, t_fetch_err;
    logic [31:0] t_imem_addr, t_out_instr, t_out_pc, t_out_pc4, t_err_pc;

    logic [31:0] pc;
    logic [31:0] flush_tgt;
    int          mem_delay;
    logic        pend;
    int          wcnt;

    int          checks = 0;
    int          failures = 0;
    int          acc_cnt = 0;
    int          wre_cnt = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc4_in(pc4_in), .pc_wre(pc_wre), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_pc4(out_pc4), .fetch_err(fetch_err), .err_pc(err_pc)
    );

    inst_fetch #(.TIMEOUT(4), .CNT_W(3)) dut_t (
        .clk(clk), .rst(rst_t), .pc_in(32'h0000_0200), .pc4_in(32'h0000_0204), .pc_wre(t_pc_wre),
        .flush(1'b0), .imem_req(t_imem_req), .imem_addr(t_imem_addr), .imem_ack(1'b0),
        .imem_rdata(32'h0), .out_valid(t_out_valid), .out_ready(1'b1), .out_instr(t_out_instr),
        .out_pc(t_out_pc), .out_pc4(t_out_pc4), .fetch_err(t_fetch_err), .err_pc(t_err_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // PC register: loads the redirect target on flush, otherwise PC+4
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 32'h0;
        else if (pc_wre) pc <= flush ? flush_tgt : pc + 32'd4;
    end
    assign pc_in  = pc;
    assign pc4_in = pc + 32'd4;

    // Memory: acks mem_delay cycles after the request starts, even if req has since dropped
    assign imem_ack   = (imem_req || pend) && (wcnt == mem_delay);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
            wcnt <= 0;
        end else if (imem_ack) begin
            pend <= 1'b0;
            wcnt <= 0;
        end else if (imem_req || pend) begin
            pend <= 1'b1;
            wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pc_wre) wre_cnt++;
            if (out_valid && out_ready) begin
                logic [31:0] exp_pc;
                acc_cnt++;
                exp_pc = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
                chk("sb_pc", out_pc, exp_pc);
                chk("sb_instr", out_instr, mem_word(exp_pc));
                chk("sb_pc4", out_pc4, exp_pc + 32'd4);
            end
        end
    end

    initial begin
        int   req_cyc;
        logic seen;

        rst = 1'b1; rst_t = 1'b1; flush = 1'b0; flush_tgt = 32'h0; out_ready = 1'b1; mem_delay = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc_wre", pc_wre, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_pc4", out_pc4, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_fetch_err", fetch_err, 0);
        chk("rst_err_pc", err_pc, 0);

        // Zero-wait memory, decode always ready: one instruction every 3 cycles
        @(posedge clk); #1;
        rst = 1'b0;
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        repeat (9) @(negedge clk);
        #1;
        chk("thru_accepts", acc_cnt, 3);
        chk("thru_pc_wre_pulses", wre_cnt, 3);

        // Decode stalls for 4 cycles in HOLD
        @(posedge clk); #1;
        out_ready = 1'b0;
        sb.push_back(32'hC);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("stall_valid_seen", seen, 1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_instr", out_instr, mem_word(32'hC));
            chk("stall_pc", out_pc, 32'hC);
            chk("stall_pc_wre", pc_wre, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_pc_wre", pc_wre, 1);

        // Redirect to 0x40 while in ISSUE, then a 5-cycle memory delay
        @(posedge clk); #1;
        flush = 1'b1; flush_tgt = 32'h40; mem_delay = 5;
        @(negedge clk);
        chk("flush_issue_pc_wre", pc_wre, 1);
        chk("flush_issue_valid", out_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        sb.push_back(32'h40);
        req_cyc = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_req) begin
                req_cyc++;
                chk("delay_addr_stable", imem_addr, 32'h40);
            end
            seen = out_valid;
        end
        chk("delay_valid_seen", seen, 1);
        chk("delay_req_cycles", req_cyc, 6);
        chk("delay_instr", out_instr, mem_word(32'h40));

        // Flush during REQ with the ack still 3 cycles away
        @(posedge clk); #1;
        mem_delay = 3;
        @(posedge clk); #1;
        flush = 1'b1; flush_tgt = 32'h100;
        @(negedge clk);
        chk("flush_req_imem_req", imem_req, 1);
        chk("flush_req_pc_wre", pc_wre, 1);
        chk("flush_req_valid", out_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        sb.push_back(32'h100);
        @(negedge clk);
        chk("drain_imem_req", imem_req, 0);
        chk("drain_valid", out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("redirect_valid_seen", seen, 1);
        chk("redirect_pc", out_pc, 32'h100);

        // Redirect to a misaligned target
        @(posedge clk); #1;
        flush = 1'b1; flush_tgt = 32'h102;
        @(negedge clk);
        chk("misalign_flush_pc_wre", pc_wre, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("misalign_issue_req", imem_req, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fault_err", fetch_err, 1);
        chk("fault_err_pc", err_pc, 32'h102);
        chk("fault_req", imem_req, 0);
        @(posedge clk); #1;
        flush = 1'b1; flush_tgt = 32'h200;
        @(negedge clk);
        chk("fault_flush_pc_wre", pc_wre, 0);
        chk("fault_flush_valid", out_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("fault_sticky", fetch_err, 1);
        chk("fault_no_req", imem_req, 0);

        // Short-timeout instance with a silent memory
        @(negedge clk);
        chk("t_rst_out_pc", t_out_pc, 0);
        @(posedge clk); #1;
        rst_t = 1'b0;
        @(negedge clk);
        chk("t_issue_req", t_imem_req, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t_req_high", t_imem_req, 1);
            chk("t_no_err_yet", t_fetch_err, 0);
        end
        @(negedge clk);
        chk("t_timeout_err", t_fetch_err, 1);
        chk("t_timeout_req", t_imem_req, 0);
        chk("t_timeout_err_pc", t_err_pc, 32'h200);
        chk("t_out_pc", t_out_pc, 32'h200);

        // Asynchronous reset mid-cycle, away from any clock edge
        #2;
        rst_t = 1'b1;
        rst = 1'b1;
        #1;
        chk("async_t_err", t_fetch_err, 0);
        chk("async_t_err_pc", t_err_pc, 0);
        chk("async_t_addr", t_imem_addr, 0);
        chk("async_t_out_pc", t_out_pc, 0);
        chk("async_t_out_pc4", t_out_pc4, 0);
        chk("async_err", fetch_err, 0);
        chk("async_err_pc", err_pc, 0);
        chk("async_out_instr", out_instr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
